// File: rtl/cla_word_sequencer_if.sv
// Request/response bundle between a client and cla_word_sequencer.
// The master drives operands and start; the slave returns status and result.
interface cla_word_sequencer_if #(
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W = 8 * NBYTES;

    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, op_a, op_b, cin,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, op_a, op_b, cin,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/cla_word_sequencer.sv
// Word-wide add/subtract built by streaming bytes LSB first through an external
// 8-bit CLA, with the inter-byte carry held in a register.
module cla_word_sequencer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_word_sequencer_if.slave  bus,
    output logic [7:0]           cla_a,
    output logic [7:0]           cla_b,
    output logic                 cla_cin,
    input  logic [7:0]           cla_sum,
    input  logic                 cla_cout
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_carry;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_result;
    logic          r_cout;
    logic          r_ovf;
    logic          r_busy;
    logic          r_done;

    logic [7:0]    w_a_byte;
    logic [7:0]    w_b_byte;
    logic          w_run;
    logic          w_last;
    logic          w_ovf;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_idx == IW'(NBYTES - 1));
    // Overflow of the top slice: operands agree in sign but the sum does not.
    assign w_ovf  = (r_a[W-1] == r_b[W-1]) & (cla_sum[7] != r_a[W-1]);

    // Byte-lane select of the captured operands for the current slice.
    always_comb begin
        w_a_byte = 8'h00;
        w_b_byte = 8'h00;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_byte = r_a[8*k +: 8];
                w_b_byte = r_b[8*k +: 8];
            end
        end
    end

    // The CLA is only fed while a word is in flight; it sees zeros otherwise.
    assign cla_a   = w_run ? w_a_byte : 8'h00;
    assign cla_b   = w_run ? w_b_byte : 8'h00;
    assign cla_cin = w_run & r_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.op_a;
                        r_b      <= bus.op_b ^ {W{bus.sub}};
                        r_carry  <= bus.sub | bus.cin;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int unsigned k = 0; k < NBYTES; k++) begin
                        if (r_idx == IW'(k)) begin
                            r_result[8*k +: 8] <= cla_sum;
                        end
                    end
                    r_carry <= cla_cout;
                    if (w_last) begin
                        r_cout  <= cla_cout;
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed self-checking bench for cla_word_sequencer with NBYTES=4 and a
// behavioural 8-bit carry-lookahead adder attached to the CLA port.
module tb_cla_word_sequencer;
    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cla_a;
    logic [7:0] cla_b;
    logic       cla_cin;
    logic [7:0] cla_sum;
    logic       cla_cout;

    int tests = 0;
    int fails = 0;

    cla_word_sequencer_if #(.NBYTES(NBYTES)) bus ();

    cla_word_sequencer #(.NBYTES(NBYTES)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cla_a    (cla_a),
        .cla_b    (cla_b),
        .cla_cin  (cla_cin),
        .cla_sum  (cla_sum),
        .cla_cout (cla_cout)
    );

    // 8-bit carry-lookahead adder: generate/propagate with expanded carries.
    always_comb begin
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        g    = cla_a & cla_b;
        p    = cla_a ^ cla_b;
        c    = '0;
        c[0] = cla_cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        cla_sum  = p ^ c[7:0];
        cla_cout = c[8];
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation; returns latency in clocks (sampling edge counted),
    // the cla_cin seen per byte slice, and the first slice's CLA operands.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic c,
                          output int lat, output logic [3:0] cins,
                          output logic [7:0] a0, output logic [7:0] b0);
        int pos;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.cin   = c;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.start = 1'b0;
        a0      = cla_a;
        b0      = cla_b;
        cins    = '0;
        cins[0] = cla_cin;
        pos     = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!bus.done && pos < 4) begin
                cins[pos] = cla_cin;
                pos++;
            end
        end
    endtask

    initial begin
        int         lat;
        int         dn;
        logic [3:0] cins;
        logic [7:0] a0;
        logic [7:0] b0;

        rst       = 1'b1;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.op_a  = 32'h1111_1111;
        bus.op_b  = 32'h2222_2222;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",    32'(bus.busy),   32'h0);
        chk("rst_done",    32'(bus.done),   32'h0);
        chk("rst_result",  bus.result,      32'h0);
        chk("rst_cout",    32'(bus.cout),   32'h0);
        chk("rst_ovf",     32'(bus.ovf),    32'h0);
        chk("rst_cla_a",   32'(cla_a),      32'h0);
        chk("rst_cla_b",   32'(cla_b),      32'h0);
        chk("rst_cla_cin", 32'(cla_cin),    32'h0);
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);

        // Small add: latency, first-slice operands, result flags
        run_op(32'h0000_000D, 32'h0000_0003, 1'b0, 1'b0, lat, cins, a0, b0);
        chk("t1_latency", 32'(lat),        32'd5);
        chk("t1_cla_a0",  32'(a0),         32'h0D);
        chk("t1_cla_b0",  32'(b0),         32'h03);
        chk("t1_result",  bus.result,      32'h0000_0010);
        chk("t1_cout",    32'(bus.cout),   32'h0);
        chk("t1_ovf",     32'(bus.ovf),    32'h0);
        chk("t1_busy",    32'(bus.busy),   32'h1);
        @(negedge clk);
        chk("t1_done_pulse", 32'(bus.done), 32'h0);
        chk("t1_busy_end",   32'(bus.busy), 32'h0);
        chk("t1_held",       bus.result,    32'h0000_0010);

        // Full carry ripple across all four slices
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, cins, a0, b0);
        chk("t2_result", bus.result,    32'h0000_0000);
        chk("t2_cout",   32'(bus.cout), 32'h1);
        chk("t2_ovf",    32'(bus.ovf),  32'h0);
        chk("t2_cins",   32'(cins),     32'h0000_000E);

        // Add with carry-in
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, lat, cins, a0, b0);
        chk("t2c_result", bus.result,    32'h2345_678A);
        chk("t2c_cout",   32'(bus.cout), 32'h0);
        chk("t2c_cin0",   32'(cins[0]),  32'h1);

        // Subtract with borrow; cin input must be ignored
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, lat, cins, a0, b0);
        chk("t3_cla_b0", 32'(b0),         32'hF8);
        chk("t3_cin0",   32'(cins[0]),    32'h1);
        chk("t3_result", bus.result,      32'hFFFF_FFFE);
        chk("t3_cout",   32'(bus.cout),   32'h0);
        chk("t3_ovf",    32'(bus.ovf),    32'h0);

        // Signed overflow, add and subtract
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, cins, a0, b0);
        chk("t4a_result", bus.result,    32'h8000_0000);
        chk("t4a_cout",   32'(bus.cout), 32'h0);
        chk("t4a_ovf",    32'(bus.ovf),  32'h1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, lat, cins, a0, b0);
        chk("t4b_result", bus.result,    32'h7FFF_FFFF);
        chk("t4b_cout",   32'(bus.cout), 32'h1);
        chk("t4b_ovf",    32'(bus.ovf),  32'h1);

        // Start pulsed while running must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 32'h0000_0001;
        bus.op_b  = 32'h0000_0002;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.op_a  = 32'hFFFF_FFFF;
        bus.op_b  = 32'h1234_5678;
        bus.sub   = 1'b1;
        bus.cin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("t5_done_count", 32'(dn),    32'd1);
        chk("t5_result",     bus.result, 32'h0000_0003);
        chk("t5_busy",       32'(bus.busy), 32'h0);

        // Reset in the middle of a run aborts it
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 32'h0101_0101;
        bus.op_b  = 32'h0202_0202;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_busy_mid",  32'(bus.busy), 32'h1);
        chk("t6_cla_a_mid", 32'(cla_a),    32'h01);
        chk("t6_partial",   bus.result,    32'h0000_0303);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy",    32'(bus.busy), 32'h0);
        chk("t6_result",  bus.result,    32'h0);
        chk("t6_cla_cin", 32'(cla_cin),  32'h0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) dn++;
            @(negedge clk);
        end
        chk("t6_no_done", 32'(dn), 32'd0);
        run_op(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, lat, cins, a0, b0);
        chk("t6_latency", 32'(lat),     32'd5);
        chk("t6_fresh",   bus.result,   32'h0303_0303);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
